// File: rtl/tlc_pkg.sv
// rtl/tlc_pkg.sv - shared state, lamp encodings and Value width for the traffic light sequencer
package tlc_pkg;

  localparam int VALUE_W = 4;

  localparam logic [2:0] LIGHT_R = 3'b100;
  localparam logic [2:0] LIGHT_Y = 3'b010;
  localparam logic [2:0] LIGHT_G = 3'b001;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_MG_BASE,
    ST_MG_HOLD,
    ST_MY,
    ST_WALK,
    ST_SG_BASE,
    ST_SG_EXT,
    ST_SY
  } tlc_state_e;

endpackage

// File: rtl/tlc_walk_latch.sv
// rtl/tlc_walk_latch.sv - pedestrian request latch, set has priority over clear
module tlc_walk_latch (
  input  logic clk,
  input  logic rst_n,
  input  logic i_set,
  input  logic i_clr,
  output logic o_q
);

  logic r_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= 1'b0;
    end else if (i_set) begin
      r_q <= 1'b1;
    end else if (i_clr) begin
      r_q <= 1'b0;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/traffic_light_sequencer.sv
// rtl/traffic_light_sequencer.sv - main/side/walk phase FSM driving the shared interval timer
module traffic_light_sequencer
  import tlc_pkg::*;
#(
  parameter logic [VALUE_W-1:0] T_BASE = 4'd6,
  parameter logic [VALUE_W-1:0] T_EXT  = 4'd3,
  parameter logic [VALUE_W-1:0] T_YEL  = 4'd2
) (
  input  logic               clk,
  input  logic               Reset_n,
  input  logic               Sensor,
  input  logic               Walk_Request,
  input  logic               expired,
  output logic [VALUE_W-1:0] Value,
  output logic               start_timer,
  output logic [2:0]         Main_Light,
  output logic [2:0]         Side_Light,
  output logic               Walk_Lamp
);

  tlc_state_e         r_state;
  tlc_state_e         w_next;
  logic [1:0]         r_blank;
  logic               w_walk;
  logic               w_qexp;
  logic               w_enter;
  logic               w_enter_walk;
  logic [2:0]         w_main;
  logic [2:0]         w_side;
  logic [VALUE_W-1:0] w_value;

  logic [2:0]         r_main;
  logic [2:0]         r_side;
  logic [VALUE_W-1:0] r_value;
  logic               r_start;
  logic               r_walk_lamp;

  // expired is stale until the timer has been reloaded, so the start cycle and the one after are masked
  assign w_qexp       = expired && (r_blank == 2'd0);
  assign w_enter      = (w_next != r_state) && (w_next != ST_MG_HOLD);
  assign w_enter_walk = (w_next == ST_WALK) && (r_state != ST_WALK);

  tlc_walk_latch u_walk_latch (
    .clk   (clk),
    .rst_n (Reset_n),
    .i_set (Walk_Request),
    .i_clr (w_enter_walk),
    .o_q   (w_walk)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_INIT:    w_next = ST_MG_BASE;
      ST_MG_BASE: if (w_qexp) w_next = (Sensor || w_walk) ? ST_MY : ST_MG_HOLD;
      ST_MG_HOLD: if (Sensor || w_walk) w_next = ST_MY;
      ST_MY:      if (w_qexp) w_next = w_walk ? ST_WALK : ST_SG_BASE;
      ST_WALK:    if (w_qexp) w_next = ST_SG_BASE;
      ST_SG_BASE: if (w_qexp) w_next = Sensor ? ST_SG_EXT : ST_SY;
      ST_SG_EXT:  if (w_qexp) w_next = ST_SY;
      ST_SY:      if (w_qexp) w_next = ST_MG_BASE;
      default:    w_next = ST_INIT;
    endcase
  end

  // Outputs decode from next state so lamps and Value move on the same edge as the state
  always_comb begin
    w_main  = LIGHT_R;
    w_side  = LIGHT_R;
    w_value = r_value;
    case (w_next)
      ST_MG_BASE: begin w_main = LIGHT_G; w_value = T_BASE; end
      ST_MG_HOLD: w_main = LIGHT_G;
      ST_MY:      begin w_main = LIGHT_Y; w_value = T_YEL; end
      ST_WALK:    w_value = T_EXT;
      ST_SG_BASE: begin w_side = LIGHT_G; w_value = T_BASE; end
      ST_SG_EXT:  begin w_side = LIGHT_G; w_value = T_EXT; end
      ST_SY:      begin w_side = LIGHT_Y; w_value = T_YEL; end
      default:    w_value = r_value;
    endcase
  end

  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state     <= ST_INIT;
      r_blank     <= 2'd0;
      r_main      <= LIGHT_R;
      r_side      <= LIGHT_R;
      r_value     <= '0;
      r_start     <= 1'b0;
      r_walk_lamp <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_main      <= w_main;
      r_side      <= w_side;
      r_value     <= w_value;
      r_start     <= w_enter;
      r_walk_lamp <= (w_next == ST_WALK);
      if (w_enter) begin
        r_blank <= 2'd2;
      end else if (r_blank != 2'd0) begin
        r_blank <= r_blank - 2'd1;
      end
    end
  end

  assign Main_Light  = r_main;
  assign Side_Light  = r_side;
  assign Value       = r_value;
  assign start_timer = r_start;
  assign Walk_Lamp   = r_walk_lamp;

endmodule

// File: tb/tb_traffic_light_sequencer.sv
// tb/tb_traffic_light_sequencer.sv - directed and random checks of traffic_light_sequencer against a phase model
module tb_traffic_light_sequencer;

  localparam int P_INIT = 0, P_MGB = 1, P_HOLD = 2, P_MY = 3, P_WALK = 4, P_SGB = 5, P_SGE = 6, P_SY = 7;
  localparam logic [2:0] R = 3'b100, Y = 3'b010, G = 3'b001;

  logic       clk = 1'b0;
  logic       Reset_n;
  logic       Sensor;
  logic       Walk_Request;
  logic       expired;
  logic [3:0] Value;
  logic       start_timer;
  logic [2:0] Main_Light;
  logic [2:0] Side_Light;
  logic       Walk_Lamp;

  traffic_light_sequencer #(.T_BASE(4'd6), .T_EXT(4'd3), .T_YEL(4'd2)) dut (
    .clk          (clk),
    .Reset_n      (Reset_n),
    .Sensor       (Sensor),
    .Walk_Request (Walk_Request),
    .expired      (expired),
    .Value        (Value),
    .start_timer  (start_timer),
    .Main_Light   (Main_Light),
    .Side_Light   (Side_Light),
    .Walk_Lamp    (Walk_Lamp)
  );

  always #5 clk = ~clk;

  // Phase table: lamps and interval per phase; keep_of marks phases that leave Value untouched
  logic [2:0] main_of [8] = '{R, G, G, Y, R, R, R, R};
  logic [2:0] side_of [8] = '{R, R, R, R, R, G, G, Y};
  logic [3:0] val_of  [8] = '{4'd0, 4'd6, 4'd0, 4'd2, 4'd3, 4'd6, 4'd3, 4'd2};
  logic       keep_of [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

  int         n_asserts = 0;
  int         n_fail = 0;
  int         m_ph, m_age;
  logic       m_walk, m_start;
  logic [3:0] m_val;
  int         tcnt = 0;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int next_ph(input int ph, input int age, input logic s, input logic wl, input logic e);
    logic q;
    q = e && (age >= 2);
    case (ph)
      P_INIT: return P_MGB;
      P_MGB:  return q ? ((s || wl) ? P_MY : P_HOLD) : ph;
      P_HOLD: return (s || wl) ? P_MY : ph;
      P_MY:   return q ? (wl ? P_WALK : P_SGB) : ph;
      P_WALK: return q ? P_SGB : ph;
      P_SGB:  return q ? (s ? P_SGE : P_SY) : ph;
      P_SGE:  return q ? P_SY : ph;
      P_SY:   return q ? P_MGB : ph;
      default: return P_INIT;
    endcase
  endfunction

  task automatic model_reset();
    m_ph = P_INIT; m_age = 0; m_walk = 1'b0; m_start = 1'b0; m_val = 4'd0;
  endtask

  task automatic model_edge(input logic s, input logic w, input logic e);
    int nx;
    nx = next_ph(m_ph, m_age, s, m_walk, e);
    if (nx == P_WALK && m_ph != P_WALK) m_walk = 1'b0;
    if (w) m_walk = 1'b1;
    m_start = (nx != m_ph) && (nx != P_HOLD);
    m_age = (nx != m_ph) ? 0 : ((m_age < 3) ? m_age + 1 : 3);
    if (!keep_of[nx]) m_val = val_of[nx];
    m_ph = nx;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".main"}, {5'd0, Main_Light}, {5'd0, main_of[m_ph]});
    chk({tag, ".side"}, {5'd0, Side_Light}, {5'd0, side_of[m_ph]});
    chk({tag, ".walk"}, {7'd0, Walk_Lamp}, {7'd0, (m_ph == P_WALK)});
    chk({tag, ".start"}, {7'd0, start_timer}, {7'd0, m_start});
    chk({tag, ".value"}, {4'd0, Value}, {4'd0, m_val});
  endtask

  // One clock: drive inputs, advance the model, clock, advance the timer model, compare
  task automatic step(input string tag, input logic s, input logic w, input logic e);
    logic       pst;
    logic [3:0] pval;
    Sensor = s; Walk_Request = w; expired = e;
    model_edge(s, w, e);
    pst = start_timer; pval = Value;
    @(posedge clk); #1;
    if (pst) tcnt = int'(pval);
    else if (tcnt != 0) tcnt--;
    check_all(tag);
  endtask

  task automatic tstep(input string tag, input logic s, input logic w);
    step(tag, s, w, (tcnt == 0));
  endtask

  initial begin
    int   walks;
    logic reached;
    logic prev_lamp;
    Reset_n = 1'b0; Sensor = 1'b0; Walk_Request = 1'b0; expired = 1'b0;
    model_reset();
    @(posedge clk); #1;
    check_all("reset");
    @(posedge clk); #1;
    check_all("reset_hold");
    Reset_n = 1'b1;

    // 1: INIT -> MG_BASE with one start pulse
    tstep("rel_mgb", 1'b0, 1'b0);
    chk("rel_value6", {4'd0, Value}, 8'd6);
    chk("rel_start", {7'd0, start_timer}, 8'd1);
    tstep("rel_mgb2", 1'b0, 1'b0);

    // 2: no demand parks in MG_HOLD; Sensor then releases to MY
    reached = 1'b0;
    for (int i = 0; i < 40 && !reached; i++) begin
      tstep("to_hold", 1'b0, 1'b0);
      reached = (m_ph == P_HOLD);
    end
    chk("hold_reached", {7'd0, reached}, 8'd1);
    tstep("hold", 1'b0, 1'b0);
    tstep("hold", 1'b0, 1'b0);
    tstep("hold_exit", 1'b1, 1'b0);
    chk("hold_my_value", {4'd0, Value}, 8'd2);
    chk("hold_my_start", {7'd0, start_timer}, 8'd1);

    // 3: Sensor high through full rotations
    for (int i = 0; i < 70; i++) tstep("sensor_cycle", 1'b1, 1'b0);

    // 4: walk pulse in MG_BASE, plus a request on the WALK entry edge that must be kept
    reached = 1'b0;
    for (int i = 0; i < 60 && !reached; i++) begin
      tstep("to_mgb", 1'b0, 1'b0);
      reached = (m_ph == P_MGB);
    end
    chk("mgb_reached", {7'd0, reached}, 8'd1);
    tstep("walk_pulse", 1'b0, 1'b1);
    walks = 0;
    prev_lamp = Walk_Lamp;
    for (int i = 0; i < 150 && walks < 2; i++) begin
      logic w;
      w = (next_ph(m_ph, m_age, 1'b0, m_walk, (tcnt == 0)) == P_WALK) && (m_ph != P_WALK);
      tstep("walk_seq", 1'b0, w);
      if (Walk_Lamp && !prev_lamp) walks++;
      prev_lamp = Walk_Lamp;
    end
    chk("walk_entries", walks[7:0], 8'd2);

    // 5: expired stuck high never skips a phase
    for (int i = 0; i < 40; i++) step("exp_high", 1'($urandom_range(0, 1)), 1'b0, 1'b1);

    // Random demand with either the timer model or random expired
    for (int blk = 0; blk < 8; blk++) begin
      for (int i = 0; i < 100; i++) begin
        logic s, w;
        s = ($urandom_range(0, 2) == 0);
        w = ($urandom_range(0, 24) == 0);
        if (blk[0]) step("rand_exp", s, w, ($urandom_range(0, 3) == 0));
        else tstep("rand_timer", s, w);
      end
    end

    // 6: asynchronous reset in the middle of SG_EXT
    reached = 1'b0;
    for (int i = 0; i < 100 && !reached; i++) begin
      tstep("to_sge", 1'b1, 1'b0);
      reached = (m_ph == P_SGE) && (m_age == 1);
    end
    chk("sge_reached", {7'd0, reached}, 8'd1);
    #2;
    Reset_n = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    @(posedge clk); #1;
    check_all("rst_low");
    Sensor = 1'b1; Walk_Request = 1'b1;
    @(posedge clk); #1;
    check_all("rst_low_inputs");
    Walk_Request = 1'b0;
    tcnt = 0;
    Reset_n = 1'b1;
    tstep("restart_mgb", 1'b0, 1'b0);
    chk("restart_main", {5'd0, Main_Light}, 8'h01);
    chk("restart_start", {7'd0, start_timer}, 8'd1);
    for (int i = 0; i < 30; i++) tstep("restart_run", 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule

// File: doc/traffic_light_sequencer.md
# traffic_light_sequencer

Finite-state controller that sequences the main/side-street lights and the pedestrian walk lamp, driving the shared interval Timer. On every phase entry it loads the Timer's 4-bit `Value` and pulses `start_timer`. It then advances on `expired`, the side-street `Sensor` and a latched `Walk_Request`. It sits between the Timer and the lamp drivers in the top-level traffic light controller.

## Interface
- `T_BASE`, default 6: base green interval loaded into `Value` (legal range 1..15).
- `T_EXT`, default 3: side-green extension interval and walk interval (1..15).
- `T_YEL`, default 2: yellow interval (1..15).
- `clk` input, 1 bit: the single clock. All logic is on its rising edge.
- `Reset_n` input, 1 bit: reset, asynchronous and active-low.
- `Sensor` input, 1 bit: side-street vehicle present. Already synchronous to `clk`; level-sampled.
- `Walk_Request` input, 1 bit: pedestrian button. Already synchronous to `clk`; any high cycle is latched.
- `expired` input, 1 bit: Timer interval done.
- `Value` output, 4 bits: interval to load into the Timer.
- `start_timer` output, 1 bit: one-cycle Timer load/start pulse.
- `Main_Light` output, 3 bits: {R,Y,G}, one-hot.
- `Side_Light` output, 3 bits: {R,Y,G}, one-hot.
- `Walk_Lamp` output, 1 bit: walk indicator.

## Operation
States and what each drives:
- INIT: both red, no walk. This is the reset state.
- MG_BASE: main G / side R, `Value`=T_BASE.
- MG_HOLD: main G / side R, timer not started.
- MY: main Y / side R, `Value`=T_YEL.
- WALK: both R, `Walk_Lamp`=1, `Value`=T_EXT.
- SG_BASE: main R / side G, `Value`=T_BASE.
- SG_EXT: main R / side G, `Value`=T_EXT.
- SY: main R / side Y, `Value`=T_YEL.

Transitions:
- INIT goes to MG_BASE unconditionally on the first edge after reset release.
- MG_BASE, on qualified `expired`:
  - goes to MY if `Sensor` or walk latched;
  - otherwise goes to MG_HOLD.
- MG_HOLD goes to MY in the first cycle that `Sensor` is high or walk is latched.
- MY, on qualified `expired`:
  - goes to WALK if walk latched;
  - otherwise goes to SG_BASE.
- WALK goes to SG_BASE on qualified `expired`.
- SG_BASE, on qualified `expired`:
  - goes to SG_EXT if `Sensor`;
  - otherwise goes to SY.
- SG_EXT goes to SY on qualified `expired`. There is a single extension only, regardless of `Sensor`.
- SY goes to MG_BASE on qualified `expired`.

Walk latch:
- Set by `Walk_Request`=1.
- Cleared on the edge that enters WALK.
- If set and clear occur in the same cycle, set wins. The request is then served on the next cycle.

Qualified `expired`:
- `expired` is ignored in the cycle `start_timer` is high and in the following cycle. This blanking masks stale `expired` from the previous interval.
- After that it is level-sensitive.

Other rules:
- Lights are never green on both streets. Every main/side switch passes through a yellow and at least one all-red or red state.
- In every state except INIT and MG_HOLD, `Value` holds its constant for the whole state.
- In INIT and MG_HOLD, `Value` keeps its last driven value.

## Timing
- All outputs are registered and decoded from next-state, so lamps, `Value` and `start_timer` change on the same edge as the state.
- `start_timer`:
  - 1 for exactly the first cycle of MG_BASE, MY, WALK, SG_BASE, SG_EXT and SY;
  - 0 in every other cycle.
- Reset values (held while `Reset_n`=0):
  - state INIT;
  - `Main_Light`=100, `Side_Light`=100;
  - `Walk_Lamp`=0, `start_timer`=0, `Value`=0;
  - walk latch cleared.
- Reset asserted mid-phase: outputs go immediately, without waiting for a clock edge, to the reset values (both red). A fresh MG_BASE with a `start_timer` pulse follows release.
- Minimum phase length is 3 cycles: start cycle, blank cycle, and at least one qualified cycle. Phase duration is otherwise set by the Timer's `oneHz_enable` cadence.
- Latency from `expired` rising (qualified) to the new lights and `start_timer`=1 is 1 clock.
- `Sensor` is sampled only at MG_BASE/MG_HOLD/SG_BASE decision edges. Sensor pulses between decision points are not remembered.

## Structure
- Shared package `tlc_pkg` holds:
  - the state enum;
  - the light encodings `LIGHT_R`=3'b100, `LIGHT_Y`=3'b010, `LIGHT_G`=3'b001;
  - the `Value` width constant (4).
- One sub-module, `tlc_walk_latch`: set/clear register with set priority and async active-low reset.
- The FSM, blanking counter (2-bit) and output registers live in the top module.
- The Timer is instantiated by the parent, not here.

## Test plan
Bench uses a Timer model; T_BASE=6, T_EXT=3, T_YEL=2.
1. Reset, then release:
   - INIT shows both red (100/100);
   - next edge gives main G, `Value`=6, `start_timer`=1 for one cycle.
2. `Sensor`=0, no walk, `expired` at end of MG_BASE:
   - goes to MG_HOLD, no `start_timer`;
   - raise `Sensor`: next edge gives MY, `Value`=2, `start_timer`=1.
3. `Sensor`=1 throughout:
   - full cycle MG_BASE(6) → MY(2) → SG_BASE(6) → SG_EXT(3) → SY(2) → MG_BASE;
   - each entry has exactly one `start_timer` pulse.
4. `Walk_Request` one-cycle pulse during MG_BASE:
   - MY is followed by WALK with `Walk_Lamp`=1, both red, `Value`=3, then SG_BASE;
   - latch clear after WALK entry;
   - request on the WALK entry edge is retained.
5. `expired` held high across a transition: no skip. The new state lasts until `expired` is high after the blanking cycles.
6. `Reset_n` pulled low mid-SG_EXT:
   - both red immediately;
   - `start_timer`=0 and `Walk_Lamp`=0 while low;
   - sequence restarts at INIT → MG_BASE.
